// File: rtl/vram_wrctrl_pkg.sv
// Shared definitions for the VRAM write-burst master: FSM encoding and AXI constants.
package vram_wrctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int         BURST_BYTES    = 64;
  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/vram_wrctrl.sv
// AXI write-burst master streaming producer pixel words into VRAM as fixed
// 8-beat INCR bursts from a 64-byte aligned base, one burst outstanding at a time.
module vram_wrctrl
  import vram_wrctrl_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int BURST_LEN          = 8,
  parameter int NBURST_WIDTH       = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              START,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     BASEADDR,
  input  logic [NBURST_WIDTH-1:0]           NBURST,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     PIX_DATA,
  input  logic                              PIX_VALID,
  output logic                              PIX_READY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR
);

  localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);

  state_t                          state;
  state_t                          next_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic [NBURST_WIDTH-1:0]         remaining_q;
  logic [7:0]                      beat_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_q;

  logic w_fire;
  logic last_beat;
  logic last_burst;

  assign w_fire     = (state == DATA) && PIX_VALID && M_AXI_WREADY;
  assign last_beat  = (beat_q == BEAT_LAST);
  assign last_burst = (remaining_q == NBURST_WIDTH'(1));

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = BEAT_LAST;
  assign M_AXI_AWSIZE  = AXI_SIZE_64;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WDATA   = (state == DATA) ? PIX_DATA : '0;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR           = err_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= next_state;
  end

  // Producer handshake is passed straight through to the W channel while in DATA.
  always_comb begin
    next_state    = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    PIX_READY     = 1'b0;
    case (state)
      IDLE: begin
        if (START && (NBURST != '0)) next_state = ADDR;
      end
      ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) next_state = DATA;
      end
      DATA: begin
        M_AXI_WVALID = PIX_VALID;
        PIX_READY    = M_AXI_WREADY;
        M_AXI_WLAST  = last_beat;
        if (w_fire && last_beat) next_state = RESP;
      end
      RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) next_state = last_burst ? IDLE : ADDR;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      awaddr_q    <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (NBURST != '0) begin
              awaddr_q    <= {BASEADDR[C_M_AXI_ADDR_WIDTH-1:6], 6'b0};
              remaining_q <= NBURST;
              beat_q      <= '0;
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_fire) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
        end
        RESP: begin
          // Address advances modulo 2^32; aligned bursts never straddle a 4 KB page.
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != AXI_RESP_OKAY) err_q <= 1'b1;
            remaining_q <= remaining_q - NBURST_WIDTH'(1);
            awaddr_q    <= awaddr_q + C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
            if (last_burst) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
